// File: rtl/vga_timing_pkg.sv
// Default 640x480@60 Hz VGA timing constants, sync window bounds and the
// screen coordinate type shared by the sync generator and the pixel generator.
package vga_timing_pkg;

   localparam int H_DISPLAY = 640;
   localparam int H_FRONT   = 16;
   localparam int H_SYNC    = 96;
   localparam int H_BACK    = 48;
   localparam int V_DISPLAY = 480;
   localparam int V_FRONT   = 10;
   localparam int V_SYNC    = 2;
   localparam int V_BACK    = 33;

   localparam int H_TOTAL = H_DISPLAY + H_FRONT + H_SYNC + H_BACK;
   localparam int V_TOTAL = V_DISPLAY + V_FRONT + V_SYNC + V_BACK;

   localparam int H_SYNC_START = H_DISPLAY + H_FRONT;
   localparam int H_SYNC_END   = H_SYNC_START + H_SYNC - 1;
   localparam int V_SYNC_START = V_DISPLAY + V_FRONT;
   localparam int V_SYNC_END   = V_SYNC_START + V_SYNC - 1;

   typedef logic [9:0] coord_t;

   // Inclusive window test used for both sync pulses.
   function automatic logic in_span(input coord_t v, input coord_t lo, input coord_t hi);
      return (v >= lo) && (v <= hi);
   endfunction

endpackage

// File: rtl/pixel_tick_div.sv
// Divides the system clock down to a one-clock pixel enable every CLK_DIV clocks.
module pixel_tick_div #(
   parameter int CLK_DIV = 4
) (
   input  logic clk,
   input  logic reset,
   output logic p_tick
);

   localparam int CW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
   localparam logic [CW-1:0] DIV_LAST = CW'(CLK_DIV - 1);

   logic [CW-1:0] div_cnt;

   always_ff @(posedge clk) begin
      if (reset || (div_cnt == DIV_LAST))
         div_cnt <= '0;
      else
         div_cnt <= div_cnt + 1'b1;
   end

   // With CLK_DIV=1 the counter is pinned at 0, so the enable is always high.
   assign p_tick = (div_cnt == DIV_LAST);

endmodule

// File: rtl/vga_sync_gen.sv
// VGA raster timing: pixel/line counters, registered active-low syncs and video_on.
// Define VGA_SYNC_FRAME_CNT_EN to add the frame_cnt / frame_tick outputs.
module vga_sync_gen
   import vga_timing_pkg::coord_t;
   import vga_timing_pkg::in_span;
#(
   parameter int CLK_DIV   = 4,
   parameter int H_DISPLAY = vga_timing_pkg::H_DISPLAY,
   parameter int H_FRONT   = vga_timing_pkg::H_FRONT,
   parameter int H_SYNC    = vga_timing_pkg::H_SYNC,
   parameter int H_BACK    = vga_timing_pkg::H_BACK,
   parameter int V_DISPLAY = vga_timing_pkg::V_DISPLAY,
   parameter int V_FRONT   = vga_timing_pkg::V_FRONT,
   parameter int V_SYNC    = vga_timing_pkg::V_SYNC,
   parameter int V_BACK    = vga_timing_pkg::V_BACK
) (
   input  logic       clk,
   input  logic       reset,
   output logic       hsync,
   output logic       vsync,
   output logic       video_on,
   output logic       p_tick,
   output logic [9:0] pixel_x,
   output logic [9:0] pixel_y
`ifdef VGA_SYNC_FRAME_CNT_EN
   ,
   output logic [7:0] frame_cnt,
   output logic       frame_tick
`endif
);

   localparam int H_TOTAL = H_DISPLAY + H_FRONT + H_SYNC + H_BACK;
   localparam int V_TOTAL = V_DISPLAY + V_FRONT + V_SYNC + V_BACK;

   localparam coord_t H_LAST   = coord_t'(H_TOTAL - 1);
   localparam coord_t V_LAST   = coord_t'(V_TOTAL - 1);
   localparam coord_t H_VIS    = coord_t'(H_DISPLAY);
   localparam coord_t V_VIS    = coord_t'(V_DISPLAY);
   localparam coord_t HS_START = coord_t'(H_DISPLAY + H_FRONT);
   localparam coord_t HS_END   = coord_t'(H_DISPLAY + H_FRONT + H_SYNC - 1);
   localparam coord_t VS_START = coord_t'(V_DISPLAY + V_FRONT);
   localparam coord_t VS_END   = coord_t'(V_DISPLAY + V_FRONT + V_SYNC - 1);

   coord_t h_cnt, v_cnt;
   coord_t h_nxt, v_nxt;

   pixel_tick_div #(
      .CLK_DIV (CLK_DIV)
   ) u_tick_div (
      .clk    (clk),
      .reset  (reset),
      .p_tick (p_tick)
   );

   always_comb begin
      h_nxt = h_cnt;
      v_nxt = v_cnt;
      if (p_tick) begin
         if (h_cnt == H_LAST) begin
            h_nxt = '0;
            v_nxt = (v_cnt == V_LAST) ? '0 : v_cnt + 1'b1;
         end else begin
            h_nxt = h_cnt + 1'b1;
         end
      end
   end

   // Syncs are decoded from the next-state counts so they change on the same
   // edge as the coordinate that enters or leaves the sync window.
   always_ff @(posedge clk) begin
      if (reset) begin
         h_cnt <= '0;
         v_cnt <= '0;
         hsync <= 1'b1;
         vsync <= 1'b1;
      end else begin
         h_cnt <= h_nxt;
         v_cnt <= v_nxt;
         hsync <= ~in_span(h_nxt, HS_START, HS_END);
         vsync <= ~in_span(v_nxt, VS_START, VS_END);
      end
   end

   assign pixel_x  = h_cnt;
   assign pixel_y  = v_cnt;
   assign video_on = (h_cnt < H_VIS) && (v_cnt < V_VIS);

`ifdef VGA_SYNC_FRAME_CNT_EN
   logic frame_wrap;
   assign frame_wrap = p_tick && (h_cnt == H_LAST) && (v_cnt == V_LAST);

   always_ff @(posedge clk) begin
      if (reset) begin
         frame_cnt  <= '0;
         frame_tick <= 1'b0;
      end else begin
         frame_tick <= frame_wrap;
         if (frame_wrap)
            frame_cnt <= frame_cnt + 1'b1;
      end
   end
`endif

endmodule

// File: tb/tb_vga_sync_gen.sv
// Bench for vga_sync_gen: default timing instance plus two reduced-timing instances
// (CLK_DIV=3 and CLK_DIV=1) checked every cycle against an arithmetic raster model.
module tb_vga_sync_gen;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic rst_a, rst_b, rst_c;
   logic rel;

   logic [9:0] a_x, a_y, b_x, b_y, c_x, c_y;
   logic       a_hs, a_vs, a_von, a_pt;
   logic       b_hs, b_vs, b_von, b_pt;
   logic       c_hs, c_vs, c_von, c_pt;
`ifdef VGA_SYNC_FRAME_CNT_EN
   logic [7:0] a_fc, b_fc, c_fc;
   logic       a_ft, b_ft, c_ft;
`endif

   vga_sync_gen dut_a (
      .clk(clk), .reset(rst_a), .hsync(a_hs), .vsync(a_vs), .video_on(a_von),
      .p_tick(a_pt), .pixel_x(a_x), .pixel_y(a_y)
`ifdef VGA_SYNC_FRAME_CNT_EN
      , .frame_cnt(a_fc), .frame_tick(a_ft)
`endif
   );

   vga_sync_gen #(
      .CLK_DIV(3), .H_DISPLAY(16), .H_FRONT(4), .H_SYNC(6), .H_BACK(4),
      .V_DISPLAY(12), .V_FRONT(2), .V_SYNC(2), .V_BACK(3)
   ) dut_b (
      .clk(clk), .reset(rst_b), .hsync(b_hs), .vsync(b_vs), .video_on(b_von),
      .p_tick(b_pt), .pixel_x(b_x), .pixel_y(b_y)
`ifdef VGA_SYNC_FRAME_CNT_EN
      , .frame_cnt(b_fc), .frame_tick(b_ft)
`endif
   );

   vga_sync_gen #(
      .CLK_DIV(1), .H_DISPLAY(16), .H_FRONT(4), .H_SYNC(6), .H_BACK(4),
      .V_DISPLAY(12), .V_FRONT(2), .V_SYNC(2), .V_BACK(3)
   ) dut_c (
      .clk(clk), .reset(rst_c), .hsync(c_hs), .vsync(c_vs), .video_on(c_von),
      .p_tick(c_pt), .pixel_x(c_x), .pixel_y(c_y)
`ifdef VGA_SYNC_FRAME_CNT_EN
      , .frame_cnt(c_fc), .frame_tick(c_ft)
`endif
   );

   int n_cmp = 0;
   int n_bad = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp = n_cmp + 1;
      if (act !== exp) begin
         n_bad = n_bad + 1;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
      end
   endtask

   // Raster model: after n non-reset edges the screen has advanced n/d pixels.
   function automatic logic [23:0] model(input longint n, input longint d,
                                         input longint hd, input longint hf,
                                         input longint hs, input longint hb,
                                         input longint vd, input longint vf,
                                         input longint vs, input longint vb);
      longint ht, vt, p, x, y;
      logic [9:0] mx, my;
      logic m_hs, m_vs, m_von, m_pt;
      ht    = hd + hf + hs + hb;
      vt    = vd + vf + vs + vb;
      p     = (n / d) % (ht * vt);
      x     = p % ht;
      y     = p / ht;
      mx    = 10'(x);
      my    = 10'(y);
      m_hs  = (x >= hd + hf && x < hd + hf + hs) ? 1'b0 : 1'b1;
      m_vs  = (y >= vd + vf && y < vd + vf + vs) ? 1'b0 : 1'b1;
      m_von = (x < hd && y < vd) ? 1'b1 : 1'b0;
      m_pt  = ((n % d) == d - 1) ? 1'b1 : 1'b0;
      return {mx, my, m_hs, m_vs, m_von, m_pt};
   endfunction

   longint n_a = 0, n_b = 0, n_c = 0, t = 0;
   bit seen_a = 1'b0, seen_b = 1'b0, seen_c = 1'b0;

   always @(posedge clk) begin
      n_a    <= rst_a ? 0 : n_a + 1;
      n_b    <= rst_b ? 0 : n_b + 1;
      n_c    <= rst_c ? 0 : n_c + 1;
      seen_a <= seen_a | rst_a;
      seen_b <= seen_b | rst_b;
      seen_c <= seen_c | rst_c;
      if (rel)
         t <= t + 1;
   end

   int refresh_b = 0, vlow_b = 0, ptlow_c = 0, ftick_c = 0;

   always @(negedge clk) begin
      if (seen_a)
         chk("scan_a", {8'h0, a_x, a_y, a_hs, a_vs, a_von, a_pt},
             {8'h0, model(n_a, 4, 640, 16, 96, 48, 480, 10, 2, 33)});
      if (seen_b)
         chk("scan_b", {8'h0, b_x, b_y, b_hs, b_vs, b_von, b_pt},
             {8'h0, model(n_b, 3, 16, 4, 6, 4, 12, 2, 2, 3)});
      if (seen_c)
         chk("scan_c", {8'h0, c_x, c_y, c_hs, c_vs, c_von, c_pt},
             {8'h0, model(n_c, 1, 16, 4, 6, 4, 12, 2, 2, 3)});
`ifdef VGA_SYNC_FRAME_CNT_EN
      if (seen_c)
         chk("frame_c", {23'h0, c_fc, c_ft},
             {23'h0, 8'((n_c / 570) % 256), ((n_c > 0) && (n_c % 570 == 0)) ? 1'b1 : 1'b0});
      if (rel && t < 1710 && c_ft)
         ftick_c = ftick_c + 1;
`endif
      if (rel && t < 1710) begin
         if (b_x == 10'd0 && b_y == 10'd13)
            refresh_b = refresh_b + 1;
         if (!b_vs)
            vlow_b = vlow_b + 1;
         if (!c_pt)
            ptlow_c = ptlow_c + 1;
      end
   end

   task automatic wait_t(input longint target);
      while (t < target)
         @(negedge clk);
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
      $fatal(1, "watchdog");
   end

   initial begin
      rst_a = 1'b1; rst_b = 1'b1; rst_c = 1'b1; rel = 1'b0;
      repeat (5) @(negedge clk);
      chk("rst_x",   {22'h0, a_x}, 32'd0);
      chk("rst_y",   {22'h0, a_y}, 32'd0);
      chk("rst_hs",  {31'h0, a_hs}, 32'd1);
      chk("rst_vs",  {31'h0, a_vs}, 32'd1);
      chk("rst_von", {31'h0, a_von}, 32'd1);
      chk("rst_pt",  {31'h0, a_pt}, 32'd0);
      rst_a = 1'b0; rst_b = 1'b0; rst_c = 1'b0; rel = 1'b1;

      wait_t(2);  chk("pt_clk3", {31'h0, a_pt}, 32'd0);
      wait_t(3);  chk("pt_clk4", {31'h0, a_pt}, 32'd1);
      wait_t(4);  chk("pt_clk5", {31'h0, a_pt}, 32'd0);
                  chk("x_step1", {22'h0, a_x}, 32'd1);
      wait_t(40); chk("x_clk40", {22'h0, a_x}, 32'd10);
                  chk("y_clk40", {22'h0, a_y}, 32'd0);

      wait_t(569);
      chk("c_last_x", {22'h0, c_x}, 32'd29);
      chk("c_last_y", {22'h0, c_y}, 32'd18);
`ifdef VGA_SYNC_FRAME_CNT_EN
      chk("c_ft_pre", {31'h0, c_ft}, 32'd0);
`endif
      wait_t(570);
      chk("c_wrap_xy", {12'h0, c_x, c_y}, 32'd0);
`ifdef VGA_SYNC_FRAME_CNT_EN
      chk("c_ft_1", {31'h0, c_ft}, 32'd1);
      chk("c_fc_1", {24'h0, c_fc}, 32'd1);
`endif

      wait_t(1709);
      chk("b_last_x", {22'h0, b_x}, 32'd29);
      chk("b_last_y", {22'h0, b_y}, 32'd18);
      wait_t(1710);
      chk("b_wrap_xy", {12'h0, b_x, b_y}, 32'd0);
      chk("b_refresh_clks", refresh_b, 32'd3);
      chk("b_vsync_low_clks", vlow_b, 32'd180);
      chk("c_ptick_low_clks", ptlow_c, 32'd0);
      chk("c_wrap3_xy", {12'h0, c_x, c_y}, 32'd0);
`ifdef VGA_SYNC_FRAME_CNT_EN
      chk("c_fc_3", {24'h0, c_fc}, 32'd3);
      chk("c_ft_3", {31'h0, c_ft}, 32'd1);
      chk("c_ft_count", ftick_c, 32'd2);
      wait_t(1711);
      chk("c_ft_post", {31'h0, c_ft}, 32'd0);
`endif

      wait_t(2559); chk("x_639",     {22'h0, a_x}, 32'd639);
                    chk("von_639",   {31'h0, a_von}, 32'd1);
      wait_t(2560); chk("x_640",     {22'h0, a_x}, 32'd640);
                    chk("von_640",   {31'h0, a_von}, 32'd0);
      wait_t(2623); chk("hs_655",    {31'h0, a_hs}, 32'd1);
      wait_t(2624); chk("hs_656",    {31'h0, a_hs}, 32'd0);
                    chk("x_656",     {22'h0, a_x}, 32'd656);
      wait_t(3007); chk("hs_751",    {31'h0, a_hs}, 32'd0);
      wait_t(3008); chk("hs_752",    {31'h0, a_hs}, 32'd1);
                    chk("x_752",     {22'h0, a_x}, 32'd752);

      wait_t(3127);
      chk("b_pre_rst_xy", {12'h0, b_x, b_y}, {12'h0, 10'd22, 10'd15});
      chk("b_pre_rst_hs", {31'h0, b_hs}, 32'd0);
      chk("b_pre_rst_vs", {31'h0, b_vs}, 32'd0);
      rst_b = 1'b1;
      @(negedge clk);
      rst_b = 1'b0;
      chk("b_rst_xy",  {12'h0, b_x, b_y}, 32'd0);
      chk("b_rst_hs",  {31'h0, b_hs}, 32'd1);
      chk("b_rst_vs",  {31'h0, b_vs}, 32'd1);
      chk("b_rst_von", {31'h0, b_von}, 32'd1);
      chk("b_rst_pt",  {31'h0, b_pt}, 32'd0);

      wait_t(3199); chk("x_799", {22'h0, a_x}, 32'd799);
                    chk("y_799", {22'h0, a_y}, 32'd0);
      wait_t(3200); chk("x_wrap", {22'h0, a_x}, 32'd0);
                    chk("y_step", {22'h0, a_y}, 32'd1);

      wait_t(6000);
      chk("a_pre_rst_xy", {12'h0, a_x, a_y}, {12'h0, 10'd700, 10'd1});
      chk("a_pre_rst_hs", {31'h0, a_hs}, 32'd0);
      rst_a = 1'b1;
      @(negedge clk);
      rst_a = 1'b0;
      chk("a_rst_xy", {12'h0, a_x, a_y}, 32'd0);
      chk("a_rst_hs", {31'h0, a_hs}, 32'd1);
      chk("a_rst_vs", {31'h0, a_vs}, 32'd1);
      chk("a_rst_pt", {31'h0, a_pt}, 32'd0);

      wait_t(6300);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule

// File: doc/vga_sync_gen.md
Name: vga_sync_gen

Overview:
Generates VGA 640x480@60 Hz timing from the system clock and produces the scan interface used by the pixel generator: pixel_x, pixel_y and video_on. It also drives the active-low hsync/vsync pins and a pixel-rate enable, p_tick. It sits between the board clock and the pixel generator. Its outputs go directly to the VGA connector and to the pixel generator's scan inputs.

Parameters:
CLK_DIV, 4, system clocks per pixel (100 MHz -> 25 MHz); legal values 1..16
H_DISPLAY, 640, visible pixels per line
H_FRONT, 16, horizontal front porch (pixels)
H_SYNC, 96, hsync pulse width (pixels)
H_BACK, 48, horizontal back porch (pixels)
V_DISPLAY, 480, visible lines per frame
V_FRONT, 10, vertical front porch (lines)
V_SYNC, 2, vsync pulse width (lines)
V_BACK, 33, vertical back porch (lines)

Ports:
clk  in  1  system clock
reset  in  1  synchronous, active-high reset
hsync  out  1  horizontal sync, active low, registered
vsync  out  1  vertical sync, active low, registered
video_on  out  1  high when pixel_x < H_DISPLAY and pixel_y < V_DISPLAY
p_tick  out  1  one-clk pixel enable, once every CLK_DIV clocks
pixel_x  out  10  current horizontal count, 0..H_TOTAL-1
pixel_y  out  10  current vertical count, 0..V_TOTAL-1

Behaviour:
- Derived constants: H_TOTAL = sum of the H_* parameters (800). V_TOTAL = sum of the V_* parameters (525).
- Divider: div_cnt counts 0..CLK_DIV-1 and wraps. p_tick = (div_cnt == CLK_DIV-1), combinational. When CLK_DIV=1, p_tick is constantly 1 outside reset.
- Horizontal counter: h_cnt advances only on p_tick. At H_TOTAL-1 it wraps to 0; otherwise it increments by 1.
- Vertical counter: v_cnt advances only on p_tick when h_cnt == H_TOTAL-1. At V_TOTAL-1 it wraps to 0; otherwise it increments by 1.
- At the last pixel of the frame (799, 524), both counters wrap to (0, 0) on the same clock edge.
- pixel_x = h_cnt and pixel_y = v_cnt, driven directly from the registers.
- hsync and vsync are registered from the next-state counts, so the sync edges line up with the count values that cause them:
  - hsync = 0 exactly while pixel_x is in [H_DISPLAY+H_FRONT, H_DISPLAY+H_FRONT+H_SYNC-1], i.e. 656..751.
  - vsync = 0 exactly while pixel_y is in [V_DISPLAY+V_FRONT, V_DISPLAY+V_FRONT+V_SYNC-1], i.e. 490..491.
- video_on is combinational from h_cnt and v_cnt; it carries no extra latency.
- Reset, applied at a clk edge while reset=1, sets div_cnt=0, h_cnt=0, v_cnt=0, hsync=1, vsync=1. Consequences:
  - p_tick=0 when CLK_DIV>1.
  - video_on=1, since (0,0) is a visible pixel.
- Reset asserted mid-frame restarts at (0,0) on the next edge; no partial sync pulse is held.
- The first p_tick after reset release occurs CLK_DIV clocks later.
- (pixel_x, pixel_y) = (0, 481) occurs exactly once per frame and lasts CLK_DIV clocks. This is the pixel generator's refresh tick.
- Frame period is H_TOTAL*V_TOTAL*CLK_DIV clocks (1,680,000 at defaults).

Optional Feature:
- Macro: VGA_SYNC_FRAME_CNT_EN.
- Defined:
  - Adds output frame_cnt[7:0], which increments (wrapping 255->0) on the clock edge where both counters wrap to (0,0).
  - Adds output frame_tick, a one-clk pulse on that same edge.
  - Both outputs reset to 0.
- Undefined: neither port nor its logic exists, and all other behaviour is identical.

Decomposition:
- Shared package vga_timing_pkg holds:
  - the default timing constants H_DISPLAY..V_BACK;
  - the derived H_TOTAL and V_TOTAL;
  - the sync window bounds;
  - the 10-bit coordinate typedef, shared with the pixel generator.
- One sub-module, pixel_tick_div: the CLK_DIV counter producing p_tick. The counters and sync logic stay in vga_sync_gen.

Test Plan:
- Reset, then hold reset 5 clks -> pixel_x=0, pixel_y=0, hsync=1, vsync=1, video_on=1, p_tick=0.
- Free run 40 clks after reset release -> p_tick high on clks 4, 8, 12, ...; pixel_x steps 0->1->...->10 once per tick.
- Run one full line -> hsync goes low when pixel_x becomes 656 and high when it becomes 752; video_on falls when pixel_x goes 639->640; pixel_y goes 0->1 when pixel_x wraps 799->0.
- Run one full frame -> vsync is low only during pixel_y 490..491; (0,0) recurs after exactly 1,680,000 clks; (0,481) is seen once.
- Assert reset for 1 clk at pixel (300,200) -> next edge (0,0), hsync=vsync=1; timing resumes cleanly.
- CLK_DIV=1 build with VGA_SYNC_FRAME_CNT_EN defined, run 3 frames -> p_tick is constant 1; frame_tick pulses every 420,000 clks; frame_cnt reads 3.
